// File: rtl/activation_unit_pkg.sv
// Shared definitions for the activation stage of the neuron PE:
// packet type codes, payload/type widths and the width derivations
// that follow from the network size.
package activation_unit_pkg;

    localparam int PAYLOAD_WIDTH = 32;
    localparam int TYPE_WIDTH    = 3;

    typedef enum logic [TYPE_WIDTH-1:0] {
        DATA       = 3'b000,
        CONF_INB   = 3'b001,
        CONF_W     = 3'b010,
        CONF_AFLUT = 3'b100,
        CONF_AFLB  = 3'b101,
        CONF_AFUB  = 3'b110
    } pkt_type_e;

    // Integer square root (floor), used only at elaboration time.
    function automatic int isqrt_f(input int n);
        int r;
        r = 32'sd0;
        while ((r + 32'sd1) * (r + 32'sd1) <= n) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    // Source/inputNum field width.
    function automatic int src_width_f(input int n);
        return $clog2(n);
    endfunction

    // Sequence number width: log2 of twice the network side length.
    function automatic int seq_width_f(input int n);
        return $clog2(isqrt_f(n) * 32'sd2);
    endfunction

    // Accumulated sum width: inputNum field on top of the payload.
    function automatic int sum_width_f(input int n);
        return $clog2(n) + PAYLOAD_WIDTH;
    endfunction

endpackage

// File: rtl/activation_unit_lut_ram.sv
// LUT storage for the activation function: one synchronous write port,
// one asynchronous read port. Contents are not reset.
module af_lut_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [0:(1 << ADDR_WIDTH)-1];

    // Write one entry when a LUT config packet is acted upon
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/activation_unit.sv
// activation_unit: receiving end of the ACC->AF link. Applies AF config
// packets (bounds and LUT entries) and maps each DATA sum through a
// bounded, shifted LUT, producing one output per DATA packet after two
// pipeline stages. Both stages freeze while downstream halts a valid output.
// Optional feature macro AF_BYPASS_EN adds the af_bypass input, which
// replaces the LUT result with the sum saturated to the output range.
module activation_unit
    import activation_unit_pkg::*;
#(
    parameter int NETWORK_SIZE   = 256,
    parameter int LUT_ADDR_WIDTH = 8,
    parameter int OUT_WIDTH      = 16,
    parameter int IDX_SHIFT      = 8,
    localparam int SRC_W         = src_width_f(NETWORK_SIZE),
    localparam int SEQ_WIDTH     = seq_width_f(NETWORK_SIZE),
    localparam int SUM_W         = sum_width_f(NETWORK_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ACC_AF_valid,
    input  logic [TYPE_WIDTH-1:0] ACC_AF_type,
    input  logic [SEQ_WIDTH-1:0]  ACC_AF_seqNum,
    input  logic [SUM_W-1:0]      ACC_AF_data,
    output logic                  ACC_AF_halt,
`ifdef AF_BYPASS_EN
    input  logic                  af_bypass,
`endif
    output logic                  AF_OUT_valid,
    output logic [SEQ_WIDTH-1:0]  AF_OUT_seqNum,
    output logic [OUT_WIDTH-1:0]  AF_OUT_data,
    input  logic                  AF_OUT_halt
);

    localparam logic [LUT_ADDR_WIDTH-1:0] LUT_TOP = {LUT_ADDR_WIDTH{1'b1}};
    localparam logic [SUM_W:0] IDX_MAX = {{(SUM_W + 1 - LUT_ADDR_WIDTH){1'b0}}, LUT_TOP};
    localparam logic signed [SUM_W-1:0] OUT_MAX = {{(SUM_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] OUT_MIN = {{(SUM_W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    logic                       stall_s;
    logic                       s1_act_s;
    logic                       s1_is_data_s;
    logic                       lut_we_s;
    logic                       s1_valid_r;
    logic [TYPE_WIDTH-1:0]      s1_type_r;
    logic [SEQ_WIDTH-1:0]       s1_seq_r;
    logic [SUM_W-1:0]           s1_data_r;
    logic signed [SUM_W-1:0]    ub_r;
    logic signed [SUM_W-1:0]    lb_r;
    logic signed [SUM_W-1:0]    sum_s;
    logic signed [SUM_W-1:0]    payload_ext_s;
    logic [SUM_W:0]             diff_s;
    logic [SUM_W:0]             shifted_s;
    logic [LUT_ADDR_WIDTH-1:0]  idx_s;
    logic [OUT_WIDTH-1:0]       lut_rdata_s;
    logic [OUT_WIDTH-1:0]       result_s;

    assign stall_s       = AF_OUT_halt & AF_OUT_valid;
    assign ACC_AF_halt   = stall_s;
    assign s1_act_s      = s1_valid_r & ~stall_s;
    assign s1_is_data_s  = (s1_type_r == DATA);
    assign sum_s         = $signed(s1_data_r);
    assign payload_ext_s = $signed({{SRC_W{s1_data_r[PAYLOAD_WIDTH-1]}}, s1_data_r[PAYLOAD_WIDTH-1:0]});
    // A reset cycle drops whatever sits in S1, including LUT writes.
    assign lut_we_s      = s1_act_s & (s1_type_r == CONF_AFLUT) & ~rst;

    af_lut_ram #(
        .ADDR_WIDTH (LUT_ADDR_WIDTH),
        .DATA_WIDTH (OUT_WIDTH)
    ) u_lut (
        .clk   (clk),
        .we    (lut_we_s),
        .waddr (s1_data_r[PAYLOAD_WIDTH +: LUT_ADDR_WIDTH]),
        .wdata (s1_data_r[OUT_WIDTH-1:0]),
        .raddr (idx_s),
        .rdata (lut_rdata_s)
    );

    // Bound-check the sum, then offset, shift and clamp it into a LUT index
    always_comb begin
        diff_s    = {sum_s[SUM_W-1], sum_s} - {lb_r[SUM_W-1], lb_r};
        shifted_s = diff_s >> IDX_SHIFT;
        idx_s     = '0;
        if (sum_s >= ub_r) begin
            idx_s = LUT_TOP;
        end else if (sum_s < lb_r) begin
            idx_s = '0;
        end else if (shifted_s > IDX_MAX) begin
            idx_s = LUT_TOP;
        end else begin
            idx_s = shifted_s[LUT_ADDR_WIDTH-1:0];
        end
    end

    // Pick the value registered into S2: LUT lookup or saturated bypass
    always_comb begin
        result_s = lut_rdata_s;
`ifdef AF_BYPASS_EN
        if (af_bypass) begin
            if (sum_s > OUT_MAX) begin
                result_s = OUT_MAX[OUT_WIDTH-1:0];
            end else if (sum_s < OUT_MIN) begin
                result_s = OUT_MIN[OUT_WIDTH-1:0];
            end else begin
                result_s = sum_s[OUT_WIDTH-1:0];
            end
        end else begin
            result_s = lut_rdata_s;
        end
`endif
    end

    // S1: capture the incoming packet whenever the pipeline moves
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_type_r  <= DATA;
            s1_seq_r   <= '0;
            s1_data_r  <= '0;
        end else if (!stall_s) begin
            s1_valid_r <= ACC_AF_valid;
            s1_type_r  <= ACC_AF_type;
            s1_seq_r   <= ACC_AF_seqNum;
            s1_data_r  <= ACC_AF_data;
        end
    end

    // Bound registers: updated by CONF_AFUB / CONF_AFLB as they leave S1
    always_ff @(posedge clk) begin
        if (rst) begin
            ub_r <= '0;
            lb_r <= '0;
        end else if (s1_act_s) begin
            case (s1_type_r)
                CONF_AFUB: ub_r <= payload_ext_s;
                CONF_AFLB: lb_r <= payload_ext_s;
                default:   ;
            endcase
        end
    end

    // S2: output registers, loaded only by DATA packets
    always_ff @(posedge clk) begin
        if (rst) begin
            AF_OUT_valid  <= 1'b0;
            AF_OUT_seqNum <= '0;
            AF_OUT_data   <= '0;
        end else if (!stall_s) begin
            AF_OUT_valid <= s1_valid_r & s1_is_data_s;
            if (s1_valid_r && s1_is_data_s) begin
                AF_OUT_seqNum <= s1_seq_r;
                AF_OUT_data   <= result_s;
            end
        end
    end

endmodule

// File: tb/tb_activation_unit.sv
// Directed testbench for activation_unit: configures bounds and LUT,
// then checks mapping, latency, stall behaviour, config ordering and
// reset, with hand-computed expected values.
module tb_activation_unit;
    import activation_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ACC_AF_valid;
    logic [2:0]  ACC_AF_type;
    logic [4:0]  ACC_AF_seqNum;
    logic [39:0] ACC_AF_data;
    logic        ACC_AF_halt;
    logic        AF_OUT_valid;
    logic [4:0]  AF_OUT_seqNum;
    logic [15:0] AF_OUT_data;
    logic        AF_OUT_halt;
`ifdef AF_BYPASS_EN
    logic        af_bypass;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0]  seq;
        logic [15:0] data;
    } out_t;
    out_t outq[$];

    activation_unit dut (
        .clk           (clk),
        .rst           (rst),
        .ACC_AF_valid  (ACC_AF_valid),
        .ACC_AF_type   (ACC_AF_type),
        .ACC_AF_seqNum (ACC_AF_seqNum),
        .ACC_AF_data   (ACC_AF_data),
        .ACC_AF_halt   (ACC_AF_halt),
`ifdef AF_BYPASS_EN
        .af_bypass     (af_bypass),
`endif
        .AF_OUT_valid  (AF_OUT_valid),
        .AF_OUT_seqNum (AF_OUT_seqNum),
        .AF_OUT_data   (AF_OUT_data),
        .AF_OUT_halt   (AF_OUT_halt)
    );

    always #5 clk = ~clk;

    // Record every output transferred downstream (valid, not halted, not resetting)
    always @(negedge clk) begin
        if (AF_OUT_valid === 1'b1 && AF_OUT_halt === 1'b0 && rst === 1'b0) begin
            outq.push_back({AF_OUT_seqNum, AF_OUT_data});
        end
    end

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one packet and hold it until the edge that accepts it.
    task automatic send(input logic [2:0] t, input logic [4:0] s, input logic [39:0] d);
        int n;
        n = 0;
        ACC_AF_valid  = 1'b1;
        ACC_AF_type   = t;
        ACC_AF_seqNum = s;
        ACC_AF_data   = d;
        while (ACC_AF_halt === 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $error("FAIL send_timeout observed=halted expected=accepted");
        end
        @(posedge clk); #1;
        ACC_AF_valid = 1'b0;
    endtask

    task automatic conf(input logic [2:0] t, input logic [7:0] num, input logic [31:0] payload);
        send(t, 5'd0, {num, payload});
    endtask

    task automatic dat(input logic [4:0] s, input logic [39:0] sum);
        send(DATA, s, sum);
    endtask

    task automatic expect_out(input string tag, input logic [4:0] s, input logic [15:0] d);
        int n;
        out_t o;
        n = 0;
        while (outq.size() == 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (outq.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=none expected=%0h", tag, d);
        end else begin
            o = outq.pop_front();
            chk({tag, "_data"}, 40'(o.data), 40'(d));
            chk({tag, "_seq"}, 40'(o.seq), 40'(s));
        end
    endtask

    task automatic expect_none(input string tag);
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk(tag, 40'(outq.size()), 40'd0);
    endtask

    initial begin
        rst           = 1'b1;
        ACC_AF_valid  = 1'b0;
        ACC_AF_type   = DATA;
        ACC_AF_seqNum = 5'd0;
        ACC_AF_data   = 40'd0;
        AF_OUT_halt   = 1'b0;
`ifdef AF_BYPASS_EN
        af_bypass     = 1'b0;
`endif

        // 1: reset
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", 40'(AF_OUT_valid), 40'd0);
        chk("rst_data", 40'(AF_OUT_data), 40'd0);
        chk("rst_seq", 40'(AF_OUT_seqNum), 40'd0);
        chk("rst_halt", 40'(ACC_AF_halt), 40'd0);

        // Default configuration: lb=-1024, ub=1024, lut[k]=10*k
        conf(CONF_AFLB, 8'd0, 32'hFFFF_FC00);
        conf(CONF_AFUB, 8'd0, 32'd1024);
        for (int k = 0; k < 256; k++) begin
            conf(CONF_AFLUT, 8'(k), 32'(10 * k));
        end

        // 2: latency and basic mapping
        dat(5'd5, 40'sd0);
        chk("lat_early_valid", 40'(AF_OUT_valid), 40'd0);
        @(posedge clk); #1;
        chk("lat_valid", 40'(AF_OUT_valid), 40'd1);
        chk("lat_data", 40'(AF_OUT_data), 40'd40);
        chk("lat_seq", 40'(AF_OUT_seqNum), 40'd5);
        expect_out("t2", 5'd5, 16'd40);
        expect_none("t2_once");

        // 3: boundaries, in order
        dat(5'd1, 40'sd1024);
        dat(5'd2, -40'sd1025);
        dat(5'd3, -40'sd1024);
        dat(5'd4, 40'sd1023);
        dat(5'd6, 40'sd5000);
        expect_out("ub_eq", 5'd1, 16'd2550);
        expect_out("below_lb", 5'd2, 16'd0);
        expect_out("lb_eq", 5'd3, 16'd0);
        expect_out("mid_1023", 5'd4, 16'd70);
        expect_out("above_ub", 5'd6, 16'd2550);
        conf(CONF_AFUB, 8'd0, 32'd0);
        conf(CONF_AFLB, 8'd0, 32'd0);
        dat(5'd7, 40'sd0);
        expect_out("ub_wins", 5'd7, 16'd2550);
        // Index clamp: wide ub, diff>>8 = 394 -> clamp to 255
        conf(CONF_AFLB, 8'd0, 32'hFFFF_FC00);
        conf(CONF_AFUB, 8'd0, 32'h7FFF_FFFF);
        dat(5'd8, 40'sd100000);
        expect_out("idx_clamp", 5'd8, 16'd2550);
        conf(CONF_AFUB, 8'd0, 32'd1024);

        // 4: downstream stall
        dat(5'd1, 40'sd0);
        dat(5'd2, 40'sd1023);
        dat(5'd3, -40'sd1024);
        AF_OUT_halt = 1'b1;
        #1;
        chk("stall_halt", 40'(ACC_AF_halt), 40'd1);
        repeat (4) begin
            @(posedge clk); #1;
            chk("stall_hold_valid", 40'(AF_OUT_valid), 40'd1);
            chk("stall_hold_data", 40'(AF_OUT_data), 40'd70);
            chk("stall_hold_seq", 40'(AF_OUT_seqNum), 40'd2);
            chk("stall_hold_halt", 40'(ACC_AF_halt), 40'd1);
        end
        AF_OUT_halt = 1'b0;
        expect_out("stall_r1", 5'd1, 16'd40);
        expect_out("stall_r2", 5'd2, 16'd70);
        expect_out("stall_r3", 5'd3, 16'd0);
        expect_none("stall_no_dup");

        // 5: LUT write seen by the next DATA; other configs produce nothing
        conf(CONF_AFLUT, 8'd4, 32'd99);
        dat(5'd9, 40'sd0);
        expect_out("lut_write", 5'd9, 16'd99);
        dat(5'd10, 40'sd1023);
        conf(CONF_INB, 8'd1, 32'h0000_1234);
        conf(CONF_W, 8'd2, 32'h0000_5678);
        dat(5'd11, -40'sd1025);
        expect_out("inter_a", 5'd10, 16'd70);
        expect_out("inter_b", 5'd11, 16'd0);
        expect_none("conf_silent");
        conf(CONF_AFLUT, 8'd4, 32'd40);

`ifdef AF_BYPASS_EN
        // 6: bypass saturation
        af_bypass = 1'b1;
        dat(5'd12, 40'sd70000);
        dat(5'd13, -40'sd70000);
        dat(5'd14, 40'sd5000);
        expect_out("byp_pos", 5'd12, 16'h7FFF);
        expect_out("byp_neg", 5'd13, 16'h8000);
        expect_out("byp_mid", 5'd14, 16'd5000);
        af_bypass = 1'b0;
`endif

        // Reset mid-stream drops both stages and clears the bounds
        dat(5'd15, 40'sd0);
        dat(5'd16, 40'sd1023);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_valid", 40'(AF_OUT_valid), 40'd0);
        chk("mid_rst_halt", 40'(ACC_AF_halt), 40'd0);
        expect_none("mid_rst_drop");
        dat(5'd17, 40'sd0);
        expect_out("bounds_reset", 5'd17, 16'd2550);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
